wb_master_bridge: RTL and testbench
===================================

# wb_master_bridge

- Bridges the picorv32 native memory interface (valid/ready, byte strobes) to a 32-bit Wishbone classic master port.
- Drives the on-chip peripheral bus that `wb_gpio` and later slaves hang off.
- Issues one single-beat transaction per CPU request.
- Handles ack, error and retry terminations, and a no-response timeout, so the CPU never hangs on a dead slave.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: max cycles `wb_cyc_o` stays high per attempt before forced error; legal range 2..65535.
- `MAX_RETRIES`, 3: number of `wb_rty_i` re-issues allowed before the request is reported as an error.

Ports (clock and reset: one clock; reset is asynchronous and active-low, named `i_clk` / `i_reset_n`):
- `i_clk`  in  1  system clock
- `i_reset_n`  in  1  asynchronous active-low reset
- `mem_valid`  in  1  CPU request valid
- `mem_instr`  in  1  instruction fetch flag; ignored except for error capture
- `mem_addr`  in  32  byte address
- `mem_wdata`  in  32  write data
- `mem_wstrb`  in  4  byte enables; 0 means read
- `mem_ready`  out  1  one-cycle completion pulse
- `mem_rdata`  out  32  read data, valid with `mem_ready`
- `wb_adr_o`  out  32  word-aligned address, `{mem_addr[31:2],2'b00}`
- `wb_dat_o`  out  32  write data
- `wb_dat_i`  in  32  read data
- `wb_sel_o`  out  4  byte selects
- `wb_we_o`  out  1  write enable
- `wb_cyc_o`, `wb_stb_o`  out  1  cycle / strobe, always equal
- `wb_cti_o`  out  3  constant 3'b000 (classic)
- `wb_bte_o`  out  2  constant 2'b00
- `wb_ack_i`, `wb_err_i`, `wb_rty_i`  in  1  slave terminations
- `o_bus_error`  out  1  one-cycle pulse with `mem_ready` on error or timeout
- `o_err_addr`  out  32  byte address of the most recent failed request
- `o_err_instr`  out  1  `mem_instr` of the most recent failed request

## Operation
- **Reset values:** every output is 0 while `i_reset_n` is low, including `mem_rdata` and `o_err_addr`. State is IDLE. Reset mid-transaction drops `wb_cyc_o` immediately and does not pulse `mem_ready`.
- **IDLE**
  - Start condition: `mem_valid=1` and `mem_ready=0`.
  - Latch address, data, `wb_we_o = |mem_wstrb`.
  - `wb_sel_o = mem_wstrb` on writes, 4'hF on reads.
  - Raise cyc/stb, clear timeout counter and retry counter, go to BUS.
- **BUS:** hold all Wishbone outputs stable. Termination priority is err > ack > rty.
  - `wb_err_i`: drop cyc/stb. Pulse `mem_ready` and `o_bus_error`, `mem_rdata` = 0, capture `o_err_addr`/`o_err_instr`. Go to IDLE.
  - `wb_ack_i`: drop cyc/stb, pulse `mem_ready`. On reads `mem_rdata` = registered `wb_dat_i`; on writes it is 0. Go to IDLE.
  - `wb_rty_i`, retry count < `MAX_RETRIES`: drop cyc/stb, increment retry count, go to RETRY.
  - `wb_rty_i`, retry count == `MAX_RETRIES`: handled as err.
  - No termination and timeout counter == `TIMEOUT_CYCLES-1`: handled as err (timeout).
  - Otherwise: increment the timeout counter.
- **RETRY:** one cycle with cyc/stb low. Clear the timeout counter, re-raise cyc/stb with the latched values, go to BUS.
- `mem_rdata` holds its value until the next completion.
- `o_err_*` hold until the next error.
- `mem_valid` dropping mid-transaction is a CPU protocol violation. The transaction still completes normally.

## Timing
- Request sampled at edge N: cyc/stb high after edge N.
- Ack asserted in the cycle after edge N+k: cyc/stb low and `mem_ready` high after edge N+k+1. Best case (combinational ack, k=0) is a 1-cycle bus phase.
- Against `wb_gpio` (registered ack): `mem_ready` high after edge N+2.
- `mem_ready` is high for exactly one cycle. A new request is never accepted in the `mem_ready` cycle, so back-to-back requests have at least one idle cycle between cyc pulses.
- Timeout: cyc/stb high for exactly `TIMEOUT_CYCLES` cycles, then low with `mem_ready`/`o_bus_error` in the next cycle.
- Each retry adds one cyc-low cycle. Worst-case request length is (`MAX_RETRIES`+1)·(`TIMEOUT_CYCLES`+1) cycles.
- Ack and rty in the same cycle: ack wins. Err with anything: err wins.

## Structure
- Package `wb_master_pkg` holds:
  - state enum (IDLE, BUS, RETRY)
  - `CTI_CLASSIC` = 3'b000
  - `BTE_LINEAR` = 2'b00
  - `ERR_RDATA` = 32'h0000_0000
- No sub-module. The timeout counter (width `$clog2(TIMEOUT_CYCLES)`) and the retry counter (width `$clog2(MAX_RETRIES+1)`) are inline.

## Test plan
- Read from `wb_gpio` model, `mem_addr`=0x0000_0003, gpio_i=0xA5:
  - `wb_adr_o`=0x0000_0000, `wb_sel_o`=0xF, `wb_we_o`=0.
  - `mem_ready` after edge N+2 with `mem_rdata`=0x0000_00A5.
- Write with `mem_wstrb`=4'b0010, `mem_wdata`=0x1234_5678:
  - `wb_sel_o`=0x2, `wb_we_o`=1, `wb_dat_o`=0x1234_5678.
  - One `mem_ready` pulse, `o_bus_error`=0.
- Slave never responds, `TIMEOUT_CYCLES`=8, `mem_addr`=0x8000_0010, `mem_instr`=1:
  - cyc high 8 cycles, then `mem_ready`+`o_bus_error` pulse.
  - `mem_rdata`=0, `o_err_addr`=0x8000_0010, `o_err_instr`=1.
- Slave returns rty twice then ack with 0xCAFE_F00D:
  - two one-cycle cyc-low gaps, then `mem_rdata`=0xCAFE_F00D, no error.
- Slave returns rty 4 times (`MAX_RETRIES`=3): error completion on the 4th rty, 3 cyc-low gaps. Same-cycle ack+err: error completion.
- Assert `i_reset_n` low mid-BUS: all outputs 0 asynchronously, no `mem_ready`. After release, a fresh read completes normally.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared types and constants for the picorv32-to-Wishbone master bridge.
//   state_e     : bridge FSM states
//   CTI_CLASSIC : cycle type identifier driven on every transfer
//   BTE_LINEAR  : burst type extension driven on every transfer
//   ERR_RDATA   : read data returned to the CPU on write or failed completions
package wb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_RETRY = 2'd2
    } state_e;

    localparam logic [2:0]  CTI_CLASSIC = 3'b000;
    localparam logic [1:0]  BTE_LINEAR  = 2'b00;
    localparam logic [31:0] ERR_RDATA   = 32'h0000_0000;

endpackage

// File: rtl/wb_master_bridge.sv
// Bridges the picorv32 native memory interface to a single-beat Wishbone
// classic master. Each CPU request becomes one bus transaction, terminated by
// ack, err, rty (re-issued up to MAX_RETRIES times) or a no-response timeout.
//   i_clk, i_reset_n      : clock, asynchronous active-low reset
//   mem_valid/instr/addr/wdata/wstrb : CPU request (wstrb == 0 means read)
//   mem_ready, mem_rdata  : one-cycle completion pulse and read data
//   wb_*_o / wb_*_i       : Wishbone classic master port
//   o_bus_error           : pulses with mem_ready on err, retry exhaustion or timeout
//   o_err_addr/o_err_instr: byte address and fetch flag of the last failed request
module wb_master_bridge
    import wb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        i_clk,
    input  logic        i_reset_n,

    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,

    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,

    output logic        o_bus_error,
    output logic [31:0] o_err_addr,
    output logic        o_err_instr
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned RTY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    state_e             state_q;
    logic               cyc_q;
    logic               we_q;
    logic [3:0]         sel_q;
    logic [31:0]        addr_q;
    logic [31:0]        dat_q;
    logic               instr_q;
    logic [TO_W-1:0]    to_cnt_q;
    logic [RTY_W-1:0]   rty_cnt_q;
    logic               mem_ready_q;
    logic [31:0]        mem_rdata_q;
    logic               bus_error_q;
    logic [31:0]        err_addr_q;
    logic               err_instr_q;

    logic               to_max;
    logic               rty_max;
    logic               fail;

    // Failure folds slave err, an exhausted retry budget and the timeout into
    // one path; ack outranks rty, err outranks everything.
    assign to_max  = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign rty_max = (rty_cnt_q == RTY_W'(MAX_RETRIES));
    assign fail    = wb_err_i
                   | (wb_rty_i & ~wb_ack_i & rty_max)
                   | (~wb_ack_i & ~wb_rty_i & to_max);

    // Bridge FSM with all outputs registered.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'h0;
            addr_q      <= 32'h0;
            dat_q       <= 32'h0;
            instr_q     <= 1'b0;
            to_cnt_q    <= '0;
            rty_cnt_q   <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= 32'h0;
            bus_error_q <= 1'b0;
            err_addr_q  <= 32'h0;
            err_instr_q <= 1'b0;
        end else begin
            mem_ready_q <= 1'b0;
            bus_error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // mem_ready_q gate keeps the completion cycle from
                    // re-accepting the request the CPU has not yet dropped.
                    if (mem_valid && !mem_ready_q) begin
                        addr_q    <= mem_addr;
                        dat_q     <= mem_wdata;
                        instr_q   <= mem_instr;
                        we_q      <= |mem_wstrb;
                        sel_q     <= (|mem_wstrb) ? mem_wstrb : 4'hF;
                        cyc_q     <= 1'b1;
                        to_cnt_q  <= '0;
                        rty_cnt_q <= '0;
                        state_q   <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (fail) begin
                        cyc_q       <= 1'b0;
                        mem_ready_q <= 1'b1;
                        bus_error_q <= 1'b1;
                        mem_rdata_q <= ERR_RDATA;
                        err_addr_q  <= addr_q;
                        err_instr_q <= instr_q;
                        state_q     <= ST_IDLE;
                    end else if (wb_ack_i) begin
                        cyc_q       <= 1'b0;
                        mem_ready_q <= 1'b1;
                        mem_rdata_q <= we_q ? ERR_RDATA : wb_dat_i;
                        state_q     <= ST_IDLE;
                    end else if (wb_rty_i) begin
                        cyc_q     <= 1'b0;
                        rty_cnt_q <= rty_cnt_q + RTY_W'(1);
                        state_q   <= ST_RETRY;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                ST_RETRY: begin
                    // One idle cycle, then re-issue with the latched request.
                    to_cnt_q <= '0;
                    cyc_q    <= 1'b1;
                    state_q  <= ST_BUS;
                end
                default: begin
                    cyc_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_ready   = mem_ready_q;
    assign mem_rdata   = mem_rdata_q;
    assign wb_adr_o    = {addr_q[31:2], 2'b00};
    assign wb_dat_o    = dat_q;
    assign wb_sel_o    = sel_q;
    assign wb_we_o     = we_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_cti_o    = CTI_CLASSIC;
    assign wb_bte_o    = BTE_LINEAR;
    assign o_bus_error = bus_error_q;
    assign o_err_addr  = err_addr_q;
    assign o_err_instr = err_instr_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge: a scripted Wishbone slave answers
// each attempt with a chosen termination after a chosen delay, and a
// request-level model predicts bus occupancy, latency and completion data.
module tb_wb_master_bridge;

    localparam int unsigned TO = 8;
    localparam int unsigned MR = 3;
    localparam int BUDGET = 200;

    localparam int T_NONE    = 0;
    localparam int T_ACK     = 1;
    localparam int T_ERR     = 2;
    localparam int T_RTY     = 3;
    localparam int T_ACK_RTY = 4;
    localparam int T_ERR_ACK = 5;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o;
    logic [2:0]  wb_cti_o;
    logic [1:0]  wb_bte_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;
    logic        o_bus_error;
    logic [31:0] o_err_addr;
    logic        o_err_instr;

    wb_master_bridge #(.TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .o_bus_error(o_bus_error), .o_err_addr(o_err_addr), .o_err_instr(o_err_instr)
    );

    always #5 i_clk = ~i_clk;

    int n_pass = 0;
    int n_total = 0;

    // Slave script: per attempt, termination type, delay in cycles after cyc rises, read data.
    int          s_typ [8];
    int          s_dly [8];
    logic [31:0] s_data[8];
    int          att;
    int          scnt;
    int          sl_ai;
    bit          sl_hit;
    bit          prev_cyc = 1'b0;

    always @(negedge i_clk) begin
        sl_ai = (att > 7) ? 7 : att;
        if (wb_cyc_o) begin
            if (!prev_cyc) scnt = 0;
            else scnt++;
            sl_hit   = (scnt == s_dly[sl_ai]);
            wb_ack_i = sl_hit && (s_typ[sl_ai] == T_ACK || s_typ[sl_ai] == T_ACK_RTY || s_typ[sl_ai] == T_ERR_ACK);
            wb_err_i = sl_hit && (s_typ[sl_ai] == T_ERR || s_typ[sl_ai] == T_ERR_ACK);
            wb_rty_i = sl_hit && (s_typ[sl_ai] == T_RTY || s_typ[sl_ai] == T_ACK_RTY);
        end else begin
            if (prev_cyc) att++;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            wb_rty_i = 1'b0;
        end
        prev_cyc = wb_cyc_o;
        sl_ai    = (att > 7) ? 7 : att;
        wb_dat_i = s_data[sl_ai];
    end

    task automatic set_attempt(input int i, input int typ, input int dly, input logic [31:0] data);
        s_typ[i]  = typ;
        s_dly[i]  = dly;
        s_data[i] = data;
    endtask

    task automatic clear_script();
        for (int i = 0; i < 8; i++) set_attempt(i, T_NONE, 0, $urandom);
        att = 0;
    endtask

    // Reference model: walks the attempt script by the bridge's termination rules.
    int          exp_high, exp_gaps;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [31:0] exp_err_addr;
    logic        exp_err_instr;

    task automatic model_txn(input logic we, input logic [31:0] addr, input logic instr);
        int retries = 0;
        bit done = 0;
        exp_high = 0; exp_gaps = 0; exp_err = 1'b0; exp_rdata = 32'h0;
        for (int a = 0; a < 8 && !done; a++) begin
            if (s_typ[a] == T_NONE || s_dly[a] >= int'(TO)) begin
                exp_high += TO; exp_err = 1'b1; done = 1;
            end else begin
                exp_high += s_dly[a] + 1;
                if (s_typ[a] == T_ERR || s_typ[a] == T_ERR_ACK) begin
                    exp_err = 1'b1; done = 1;
                end else if (s_typ[a] == T_ACK || s_typ[a] == T_ACK_RTY) begin
                    exp_rdata = we ? 32'h0 : s_data[a]; done = 1;
                end else if (retries == int'(MR)) begin
                    exp_err = 1'b1; done = 1;
                end else begin
                    retries++; exp_gaps++;
                end
            end
        end
        if (exp_err) begin
            exp_err_addr  = addr;
            exp_err_instr = instr;
        end
    endtask

    // Observations from one request.
    int          obs_lat, obs_high, obs_gaps, obs_bad;
    bit          obs_seen, obs_after_ok;
    logic        obs_err;
    logic [31:0] obs_rdata, obs_adr, obs_dat;
    logic [3:0]  obs_sel;
    logic        obs_we;

    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic instr);
        bit got = 0;
        bit prev_s = 0;
        obs_lat = 0; obs_high = 0; obs_gaps = 0; obs_bad = 0; obs_seen = 0;
        obs_err = 1'b0; obs_rdata = 32'h0; obs_adr = 32'h0; obs_dat = 32'h0;
        obs_sel = 4'h0; obs_we = 1'b0;
        @(negedge i_clk);
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata;
        mem_wstrb = wstrb; mem_instr = instr;
        @(posedge i_clk); #1;
        while (!obs_seen && obs_lat <= BUDGET) begin
            if (wb_cyc_o) begin
                if (!got) begin
                    obs_adr = wb_adr_o; obs_dat = wb_dat_o; obs_sel = wb_sel_o; obs_we = wb_we_o; got = 1;
                end else if (wb_adr_o !== obs_adr || wb_dat_o !== obs_dat ||
                             wb_sel_o !== obs_sel || wb_we_o !== obs_we) begin
                    obs_bad++;
                end
                obs_high++;
            end
            if (wb_stb_o !== wb_cyc_o || wb_cti_o !== 3'b000 || wb_bte_o !== 2'b00) obs_bad++;
            if (prev_s && !wb_cyc_o && !mem_ready) obs_gaps++;
            if (mem_ready) begin
                obs_seen = 1; obs_rdata = mem_rdata; obs_err = o_bus_error; mem_valid = 1'b0;
            end else begin
                if (o_bus_error) obs_bad++;
                prev_s = wb_cyc_o;
                @(posedge i_clk); #1;
                obs_lat++;
            end
        end
        mem_valid = 1'b0;
        @(posedge i_clk); #1;
        obs_after_ok = !mem_ready && !wb_cyc_o && !o_bus_error;
    endtask

    task automatic test_reset();
        n_total++;
        if ({mem_ready, mem_rdata, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
             o_bus_error, o_err_addr, o_err_instr} !== '0)
            $display("FAIL reset_outputs: got nonzero output, ready=%b cyc=%b adr=%h", mem_ready, wb_cyc_o, wb_adr_o);
        else n_pass++;
        n_total++;
        if ({wb_cti_o, wb_bte_o} !== 5'b0) $display("FAIL reset_cti_bte: got %b required 0", {wb_cti_o, wb_bte_o});
        else n_pass++;
        exp_err_addr = 32'h0; exp_err_instr = 1'b0;
    endtask

    task automatic test_gpio_read();
        clear_script();
        set_attempt(0, T_ACK, 1, 32'h0000_00A5);
        model_txn(1'b0, 32'h0000_0003, 1'b0);
        do_txn(32'h0000_0003, 32'hDEAD_BEEF, 4'b0000, 1'b0);
        n_total++; if (obs_adr !== 32'h0) $display("FAIL gpio_adr: got %h required 00000000", obs_adr); else n_pass++;
        n_total++; if (obs_sel !== 4'hF) $display("FAIL gpio_sel: got %h required f", obs_sel); else n_pass++;
        n_total++; if (obs_we !== 1'b0) $display("FAIL gpio_we: got %b required 0", obs_we); else n_pass++;
        n_total++; if (obs_lat !== 2) $display("FAIL gpio_latency: got %0d required 2", obs_lat); else n_pass++;
        n_total++; if (obs_rdata !== 32'h0000_00A5) $display("FAIL gpio_rdata: got %h required 000000a5", obs_rdata); else n_pass++;
        n_total++; if (obs_err !== 1'b0 || obs_bad != 0) $display("FAIL gpio_clean: err=%b bad=%0d required 0/0", obs_err, obs_bad); else n_pass++;
    endtask

    task automatic test_write();
        clear_script();
        set_attempt(0, T_ACK, 1, 32'hFFFF_FFFF);
        model_txn(1'b1, 32'h0000_0004, 1'b0);
        do_txn(32'h0000_0004, 32'h1234_5678, 4'b0010, 1'b0);
        n_total++; if (obs_sel !== 4'h2) $display("FAIL write_sel: got %h required 2", obs_sel); else n_pass++;
        n_total++; if (obs_we !== 1'b1) $display("FAIL write_we: got %b required 1", obs_we); else n_pass++;
        n_total++; if (obs_dat !== 32'h1234_5678) $display("FAIL write_dat: got %h required 12345678", obs_dat); else n_pass++;
        n_total++; if (!obs_seen || !obs_after_ok) $display("FAIL write_one_ready: seen=%b after_ok=%b required 1/1", obs_seen, obs_after_ok); else n_pass++;
        n_total++; if (obs_err !== 1'b0) $display("FAIL write_err: got %b required 0", obs_err); else n_pass++;
        n_total++; if (obs_rdata !== 32'h0) $display("FAIL write_rdata: got %h required 0", obs_rdata); else n_pass++;
    endtask

    task automatic test_timeout();
        clear_script();
        model_txn(1'b0, 32'h8000_0010, 1'b1);
        do_txn(32'h8000_0010, 32'h0, 4'b0000, 1'b1);
        n_total++; if (obs_high !== 8) $display("FAIL timeout_cyc_high: got %0d required 8", obs_high); else n_pass++;
        n_total++; if (obs_lat !== 8) $display("FAIL timeout_latency: got %0d required 8", obs_lat); else n_pass++;
        n_total++; if (obs_err !== 1'b1) $display("FAIL timeout_err: got %b required 1", obs_err); else n_pass++;
        n_total++; if (obs_rdata !== 32'h0) $display("FAIL timeout_rdata: got %h required 0", obs_rdata); else n_pass++;
        n_total++; if (o_err_addr !== 32'h8000_0010) $display("FAIL timeout_err_addr: got %h required 80000010", o_err_addr); else n_pass++;
        n_total++; if (o_err_instr !== 1'b1) $display("FAIL timeout_err_instr: got %b required 1", o_err_instr); else n_pass++;
    endtask

    task automatic test_retry();
        clear_script();
        set_attempt(0, T_RTY, 0, 32'h0);
        set_attempt(1, T_RTY, 2, 32'h0);
        set_attempt(2, T_ACK, 1, 32'hCAFE_F00D);
        model_txn(1'b0, 32'h0000_0100, 1'b0);
        do_txn(32'h0000_0100, 32'h0, 4'b0000, 1'b0);
        n_total++; if (obs_gaps !== 2) $display("FAIL retry_gaps: got %0d required 2", obs_gaps); else n_pass++;
        n_total++; if (obs_rdata !== 32'hCAFE_F00D) $display("FAIL retry_rdata: got %h required cafef00d", obs_rdata); else n_pass++;
        n_total++; if (obs_err !== 1'b0) $display("FAIL retry_err: got %b required 0", obs_err); else n_pass++;
        n_total++; if (obs_lat !== 8) $display("FAIL retry_latency: got %0d required 8", obs_lat); else n_pass++;
    endtask

    task automatic test_retry_exhaust();
        clear_script();
        for (int i = 0; i < 4; i++) set_attempt(i, T_RTY, 0, 32'h1111_1111);
        set_attempt(4, T_ACK, 0, 32'h2222_2222);
        model_txn(1'b0, 32'h0000_0200, 1'b0);
        do_txn(32'h0000_0200, 32'h0, 4'b0000, 1'b0);
        n_total++; if (obs_err !== 1'b1) $display("FAIL exhaust_err: got %b required 1", obs_err); else n_pass++;
        n_total++; if (obs_gaps !== 3) $display("FAIL exhaust_gaps: got %0d required 3", obs_gaps); else n_pass++;
        n_total++; if (obs_lat !== 7) $display("FAIL exhaust_latency: got %0d required 7", obs_lat); else n_pass++;
        clear_script();
        set_attempt(0, T_ERR_ACK, 1, 32'h3333_3333);
        model_txn(1'b0, 32'h0000_0304, 1'b1);
        do_txn(32'h0000_0304, 32'h0, 4'b0000, 1'b1);
        n_total++; if (obs_err !== 1'b1 || obs_rdata !== 32'h0) $display("FAIL ack_err_same_cycle: err=%b rdata=%h required 1/0", obs_err, obs_rdata); else n_pass++;
        n_total++; if (o_err_addr !== 32'h0000_0304) $display("FAIL ack_err_addr: got %h required 00000304", o_err_addr); else n_pass++;
        clear_script();
        set_attempt(0, T_ACK_RTY, 0, 32'h4444_4444);
        model_txn(1'b0, 32'h0000_0308, 1'b0);
        do_txn(32'h0000_0308, 32'h0, 4'b0000, 1'b0);
        n_total++; if (obs_err !== 1'b0 || obs_rdata !== 32'h4444_4444 || obs_gaps !== 0)
            $display("FAIL ack_rty_same_cycle: err=%b rdata=%h gaps=%0d required 0/44444444/0", obs_err, obs_rdata, obs_gaps);
        else n_pass++;
    endtask

    // CPU holds valid: each request takes bus cycle, ready cycle, idle cycle.
    task automatic test_back_to_back();
        clear_script();
        for (int i = 0; i < 8; i++) set_attempt(i, T_ACK, 0, 32'hB000_0000 + 32'(i));
        @(negedge i_clk);
        mem_valid = 1'b1; mem_addr = 32'h0000_0040; mem_wstrb = 4'b0000; mem_instr = 1'b0;
        @(posedge i_clk); #1;
        for (int i = 0; i < 9; i++) begin
            n_total++;
            if (wb_cyc_o !== (i % 3 == 0) || mem_ready !== (i % 3 == 1))
                $display("FAIL b2b_cycle%0d: cyc=%b ready=%b required %b/%b", i, wb_cyc_o, mem_ready, i % 3 == 0, i % 3 == 1);
            else n_pass++;
            if (i % 3 == 1) begin
                n_total++;
                if (mem_rdata !== 32'hB000_0000 + 32'(i / 3)) $display("FAIL b2b_rdata%0d: got %h required %h", i / 3, mem_rdata, 32'hB000_0000 + 32'(i / 3));
                else n_pass++;
            end
            @(posedge i_clk); #1;
        end
        mem_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit ready_seen = 0;
        clear_script();
        @(negedge i_clk);
        mem_valid = 1'b1; mem_addr = 32'h0000_0500; mem_wstrb = 4'b0000; mem_instr = 1'b0;
        repeat (4) @(posedge i_clk);
        #2 i_reset_n = 1'b0;
        #1;
        mem_valid = 1'b0;
        n_total++;
        if ({mem_ready, mem_rdata, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
             o_bus_error, o_err_addr, o_err_instr} !== '0)
            $display("FAIL midreset_outputs: cyc=%b adr=%h err_addr=%h required all 0", wb_cyc_o, wb_adr_o, o_err_addr);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk); #1;
            if (mem_ready) ready_seen = 1;
        end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge i_clk); #1;
            if (mem_ready || wb_cyc_o) ready_seen = 1;
        end
        n_total++; if (ready_seen) $display("FAIL midreset_no_ready: got activity required none"); else n_pass++;
        exp_err_addr = 32'h0; exp_err_instr = 1'b0;
        clear_script();
        set_attempt(0, T_ACK, 1, 32'h5A5A_0001);
        model_txn(1'b0, 32'h0000_0600, 1'b0);
        do_txn(32'h0000_0600, 32'h0, 4'b0000, 1'b0);
        n_total++; if (obs_rdata !== 32'h5A5A_0001 || obs_lat !== 2 || obs_err !== 1'b0)
            $display("FAIL midreset_fresh_read: rdata=%h lat=%0d err=%b required 5a5a0001/2/0", obs_rdata, obs_lat, obs_err);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            logic [31:0] addr, wdata;
            logic [3:0]  wstrb;
            logic        instr;
            int          r;
            addr  = $urandom;
            wdata = $urandom;
            wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            instr = 1'($urandom_range(0, 1));
            att = 0;
            for (int i = 0; i < 8; i++) begin
                r = $urandom_range(0, 9);
                s_typ[i] = (r == 0) ? T_NONE : (r <= 3) ? T_ACK : (r == 4) ? T_ERR :
                           (r <= 7) ? T_RTY : (r == 8) ? T_ACK_RTY : T_ERR_ACK;
                s_dly[i] = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO + 1) : $urandom_range(0, 4);
                s_data[i] = $urandom;
            end
            model_txn(wstrb != 4'h0, addr, instr);
            do_txn(addr, wdata, wstrb, instr);
            n_total++; if (!obs_seen) $display("FAIL rnd%0d_no_completion: waited %0d cycles", t, obs_lat); else n_pass++;
            n_total++; if (obs_lat !== exp_high + exp_gaps) $display("FAIL rnd%0d_latency: got %0d required %0d", t, obs_lat, exp_high + exp_gaps); else n_pass++;
            n_total++; if (obs_high !== exp_high || obs_gaps !== exp_gaps)
                $display("FAIL rnd%0d_bus_shape: high=%0d gaps=%0d required %0d/%0d", t, obs_high, obs_gaps, exp_high, exp_gaps);
            else n_pass++;
            n_total++; if (obs_err !== exp_err || obs_rdata !== exp_rdata)
                $display("FAIL rnd%0d_result: err=%b rdata=%h required %b/%h", t, obs_err, obs_rdata, exp_err, exp_rdata);
            else n_pass++;
            n_total++; if (o_err_addr !== exp_err_addr || o_err_instr !== exp_err_instr)
                $display("FAIL rnd%0d_err_capture: addr=%h instr=%b required %h/%b", t, o_err_addr, o_err_instr, exp_err_addr, exp_err_instr);
            else n_pass++;
            n_total++; if (obs_adr !== {addr[31:2], 2'b00} || obs_we !== (wstrb != 4'h0) ||
                           obs_sel !== ((wstrb != 4'h0) ? wstrb : 4'hF) || obs_dat !== wdata)
                $display("FAIL rnd%0d_wb_request: adr=%h we=%b sel=%h dat=%h required %h/%b/%h/%h", t, obs_adr, obs_we, obs_sel, obs_dat,
                         {addr[31:2], 2'b00}, wstrb != 4'h0, (wstrb != 4'h0) ? wstrb : 4'hF, wdata);
            else n_pass++;
            n_total++; if (obs_bad != 0 || !obs_after_ok)
                $display("FAIL rnd%0d_protocol: unstable/illegal cycles=%0d after_ok=%b required 0/1", t, obs_bad, obs_after_ok);
            else n_pass++;
        end
    endtask

    initial begin
        i_reset_n = 1'b0;
        mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = 32'h0;
        clear_script();
        repeat (3) @(posedge i_clk);
        #1;
        test_reset();
        @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (2) @(posedge i_clk);
        test_gpio_read();
        test_write();
        test_timeout();
        test_retry();
        test_retry_exhaust();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
